// File: rtl/act_skew_feeder_pkg.sv
// Shared types and defaults for the activation skew feeder that drives the
// west edge of a systolic array.
package act_skew_feeder_pkg;

  localparam int unsigned ASF_DATA_W = 32;
  localparam int unsigned ASF_N      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } asf_state_e;

  // Drain counter runs 0..n-2, so it needs enough bits to hold n-2.
  function automatic int unsigned drain_cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n - 1) : 1;
  endfunction

endpackage

// File: rtl/act_skew_feeder_skew_delay_line.sv
// One row of the skew: DEPTH+1 shift registers, so depth 0 is a single
// pass-through output register and depth i delays its row by i beats.
module skew_delay_line #(
  parameter int unsigned DEPTH  = 0,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int D = int'(DEPTH);

  logic [DATA_W-1:0] stage_q [D+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= D; s++) stage_q[s] <= '0;
    end else if (clear_i) begin
      for (int s = 0; s <= D; s++) stage_q[s] <= '0;
    end else if (shift_en_i) begin
      stage_q[0] <= data_i;
      for (int s = 1; s <= D; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign data_o = stage_q[D];

endmodule

// File: rtl/act_skew_feeder.sv
// Accepts activation vectors, skews row i by i beats toward the array's west
// edge, flushes the skew with zeros after the last beat and pulses done.
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int unsigned N      = ASF_N,
  parameter int unsigned DATA_W = ASF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] act_west,
  output logic                compute,
  output logic                done,
  output asf_state_e          dbg_state_o
);

  // Handshake: a vector moves on a rising edge where in_valid && in_ready;
  // in_ready depends on state only, and in_data/in_last are ignored otherwise.

  localparam int unsigned CW         = drain_cnt_w(N);
  localparam bit          SKIP_DRAIN = (N == 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 2);

  asf_state_e             state_q;
  logic [CW-1:0]          drain_cnt_q;
  logic                   compute_q;
  logic                   done_q;

  logic                   accept;
  logic                   drain_step;
  logic                   shift_en;
  logic                   clear;
  logic                   last_drain;
  logic [N*DATA_W-1:0]    shift_data;

  assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_STREAM);
  assign accept     = in_valid && in_ready;
  assign drain_step = (state_q == ST_DRAIN);
  assign shift_en   = accept || drain_step;
  // Leaving DONE wipes the skew so the next tile never sees stale rows.
  assign clear      = (state_q == ST_DONE);
  assign last_drain = (N <= 2) || (drain_cnt_q == LAST_CNT);
  assign shift_data = accept ? in_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      compute_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      compute_q <= shift_en;
      done_q    <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (!in_last) begin
              state_q <= ST_STREAM;
            end else if (SKIP_DRAIN) begin
              state_q <= ST_DONE;
            end else begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (last_drain) begin
            state_q <= ST_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < int'(N); r++) begin : g_row
    skew_delay_line #(
      .DEPTH  (r),
      .DATA_W (DATA_W)
    ) u_line (
      .clk        (clk),
      .rst_n      (rst),
      .shift_en_i (shift_en),
      .clear_i    (clear),
      .data_i     (shift_data[r*DATA_W +: DATA_W]),
      .data_o     (act_west[r*DATA_W +: DATA_W])
    );
  end

  assign compute     = compute_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed and randomized tiles on an N=4 and an N=1 feeder, checked cycle by
// cycle against a beat-history model of the skew.
module tb_act_skew_feeder;
  import act_skew_feeder_pkg::*;

  localparam int W  = 32;
  localparam int NM = 4;
  localparam int VW = NM * W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          v4 = 1'b0, l4 = 1'b0, rdy4, cmp4, done4;
  logic [VW-1:0] d4 = '0, aw4;
  asf_state_e    st4;
  logic          v1 = 1'b0, l1 = 1'b0, rdy1, cmp1, done1;
  logic [W-1:0]  d1 = '0, aw1;
  asf_state_e    st1;

  int checks = 0;
  int errors = 0;

  // Reference model: every shift event appends one vector (a beat or a zero
  // flush); row i shows the vector appended i events ago.
  logic [VW-1:0] hist[$];
  logic [VW-1:0] beats[$];
  int            stalls[$];
  bit            post_active = 1'b0;
  int            pcount = 0;
  int            n_cur = NM;

  always #5 clk = ~clk;

  act_skew_feeder #(.N(NM), .DATA_W(W)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_last(l4), .act_west(aw4), .compute(cmp4), .done(done4),
    .dbg_state_o(st4)
  );

  act_skew_feeder #(.N(1), .DATA_W(W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_last(l1), .act_west(aw1), .compute(cmp1), .done(done1),
    .dbg_state_o(st1)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_west();
    logic [VW-1:0] e;
    int sz;
    e  = '0;
    sz = hist.size();
    for (int i = 0; i < n_cur; i++)
      if (sz > i) e[i*W +: W] = hist[sz-1-i][i*W +: W];
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_model();
    hist.delete();
    post_active = 1'b0;
    pcount      = 0;
  endtask

  task automatic step(input bit use1, input bit v, input logic [VW-1:0] d, input bit last);
    bit            acc;
    bit            exp_cmp;
    bit            exp_done;
    logic [VW-1:0] aw;
    if (use1) begin
      v1 = v; d1 = d[W-1:0]; l1 = last; v4 = 1'b0;
    end else begin
      v4 = v; d4 = d; l4 = last; v1 = 1'b0;
    end
    check(use1 ? "in_ready_n1" : "in_ready_n4", VW'(use1 ? rdy1 : rdy4), VW'(!post_active));
    acc      = v && !post_active;
    exp_cmp  = 1'b0;
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    if (acc) begin
      hist.push_back(d);
      exp_cmp = 1'b1;
      if (last) begin
        post_active = 1'b1;
        pcount      = 0;
      end
    end else if (post_active) begin
      pcount++;
      if (pcount < n_cur) begin
        hist.push_back('0);
        exp_cmp = 1'b1;
      end else begin
        hist.delete();
        post_active = 1'b0;
        exp_done    = 1'b1;
      end
    end
    aw = use1 ? VW'(aw1) : aw4;
    check(use1 ? "act_west_n1" : "act_west_n4", aw, exp_west());
    check(use1 ? "compute_n1" : "compute_n4", VW'(use1 ? cmp1 : cmp4), VW'(exp_cmp));
    check(use1 ? "done_n1" : "done_n4", VW'(use1 ? done1 : done4), VW'(exp_done));
  endtask

  // Drives beats[] with stalls[] idle cycles before each, then the flush.
  task automatic run_tile(input bit use1);
    for (int j = 0; j < beats.size(); j++) begin
      for (int s = 0; s < stalls[j]; s++) step(use1, 1'b0, rand_vec(), 1'($urandom_range(0, 1)));
      step(use1, 1'b1, beats[j], j == beats.size() - 1);
    end
    for (int c = 0; c < n_cur; c++) step(use1, 1'b0, rand_vec(), 1'($urandom_range(0, 1)));
  endtask

  task automatic make_random_tile(input int max_len, input int max_stall);
    int len;
    beats.delete();
    stalls.delete();
    len = $urandom_range(1, max_len);
    for (int j = 0; j < len; j++) begin
      beats.push_back(rand_vec());
      stalls.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, max_stall));
    end
  endtask

  initial begin
    logic [VW-1:0] v;

    // Reset state
    #3;
    check("rst_act_west_n4", aw4, '0);
    check("rst_compute_n4", VW'(cmp4), '0);
    check("rst_done_n4", VW'(done4), '0);
    check("rst_state_n4", VW'(st4), VW'(ST_IDLE));
    check("rst_act_west_n1", VW'(aw1), '0);
    check("rst_ready_n1", VW'(rdy1), VW'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    n_cur = NM;
    step(1'b0, 1'b0, rand_vec(), 1'b0);

    // Basic skew: beats {1,2,3,4},{5,6,7,8},{9,10,11,12}
    beats.delete();
    stalls.delete();
    for (int b = 0; b < 3; b++) begin
      v = '0;
      for (int i = 0; i < NM; i++) v[i*W +: W] = W'(4 * b + i + 1);
      beats.push_back(v);
      stalls.push_back(0);
    end
    run_tile(1'b0);
    step(1'b0, 1'b0, rand_vec(), 1'b1);

    // Same tile with a 2-cycle stall between beats 1 and 2
    stalls[1] = 2;
    run_tile(1'b0);

    // Single-beat tile {7,7,7,7}
    beats.delete();
    stalls.delete();
    v = '0;
    for (int i = 0; i < NM; i++) v[i*W +: W] = W'(7);
    beats.push_back(v);
    stalls.push_back(0);
    run_tile(1'b0);

    // Reset during the 2nd drain cycle
    make_random_tile(4, 1);
    for (int j = 0; j < beats.size(); j++) step(1'b0, 1'b1, beats[j], j == beats.size() - 1);
    step(1'b0, 1'b0, rand_vec(), 1'b0);
    check("pre_rst_state_n4", VW'(st4), VW'(ST_DRAIN));
    rst = 1'b0;
    #1;
    check("mid_rst_act_west", aw4, '0);
    check("mid_rst_compute", VW'(cmp4), '0);
    check("mid_rst_done", VW'(done4), '0);
    check("mid_rst_state", VW'(st4), VW'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, rand_vec(), 1'b0);

    // Back-to-back tiles, then randomized tiles with stalls
    make_random_tile(5, 2);
    run_tile(1'b0);
    make_random_tile(5, 2);
    run_tile(1'b0);
    for (int t = 0; t < 10; t++) begin
      make_random_tile(7, 3);
      run_tile(1'b0);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, rand_vec(), 1'b1);
    end

    // N=1: a 2-beat tile, then randomized tiles
    n_cur = 1;
    reset_model();
    beats.delete();
    stalls.delete();
    beats.push_back(VW'(32'h11));
    beats.push_back(VW'(32'h22));
    stalls.push_back(0);
    stalls.push_back(0);
    run_tile(1'b1);
    for (int t = 0; t < 8; t++) begin
      make_random_tile(5, 2);
      run_tile(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4: number of systolic-array rows fed (N >= 1).
REQ-002 SHALL have parameter DATA_W, default 32: activation width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: an activation vector is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the offered vector this cycle.
REQ-007 SHALL have port in_data, input, N*DATA_W: activation vector; slice i feeds row i.
REQ-008 SHALL have port in_last, input, 1: the offered vector is the final one of the tile.
REQ-009 SHALL have port act_west, output, N*DATA_W: skewed activations to the west edge of the array; slice i drives row i.
REQ-010 SHALL have port compute, output, 1: array-wide advance enable, aligned with act_west.
REQ-011 SHALL have port done, output, 1: single-cycle pulse when the tile is fully flushed.

Function
REQ-012 SHALL define accept as in_valid && in_ready at a rising edge.
REQ-013 SHALL implement states IDLE, STREAM, DRAIN and DONE.
REQ-014 SHALL drive in_ready = 1 in IDLE and STREAM, and 0 in DRAIN and DONE; in_ready is a combinational function of state only.
REQ-015 SHALL leave IDLE for STREAM on accept with in_last = 0, or for DRAIN on accept with in_last = 1; without accept it stays in IDLE.
REQ-016 SHALL leave STREAM for DRAIN on accept with in_last = 1.
REQ-017 SHALL stay in DRAIN for exactly N-1 cycles with compute = 1 and zeros injected into the skew, then enter DONE; if N = 1, DRAIN is skipped and the accepted last beat leads directly to DONE.
REQ-018 SHALL hold DONE for one cycle with done = 1, then return to IDLE.
REQ-019 SHALL give row i a register delay of i beats, so that after beat k is accepted, act_west[i] = in_data[i] of beat k-i (0 if k-i < 0 within the tile).
REQ-020 SHALL make act_west and compute registered outputs: compute = 1 in the cycle immediately after each accept, or after each drain step, and 0 otherwise.
REQ-021 SHALL stall when STREAM sees no accept: compute = 0, and all skew registers and act_west hold their values.
REQ-022 SHALL pass data unmodified, with no arithmetic and full DATA_W width.
REQ-023 SHALL clear all skew registers to 0 on entering IDLE from DONE, so the next tile starts clean.
REQ-024 SHALL ignore in_data and in_last when no accept occurs.

Reset
REQ-025 SHALL, while rst = 0, force state to IDLE, act_west to 0, compute to 0, done to 0 and all skew registers to 0, asynchronously.
REQ-026 SHALL abandon any in-flight tile on reset assertion mid-STREAM or mid-DRAIN, with no done pulse.
REQ-027 SHALL present in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place DATA_W, the default N and the state enumeration in a shared package.
REQ-029 SHALL instantiate sub-module skew_delay_line once per row, parameterised by depth i, with a shift enable and a synchronous clear; the depth-0 instance is a pass-through register.

Verification
REQ-030 SHALL test basic skew with N=4: accept 3 back-to-back beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, with the last beat flagged -> act_west row0 = 1,5,9,0,0,0; row3 = 0,0,0,4,8,12; compute high for 6 cycles; done pulses on cycle 7.
REQ-031 SHALL test stall: deassert in_valid for 2 cycles between beats 1 and 2 -> compute = 0 and act_west unchanged for those 2 cycles; final outputs are identical to REQ-030 apart from the time shift.
REQ-032 SHALL test a single-beat tile: one beat {7,7,7,7} with in_last=1 -> 4 compute cycles; in_ready low for 4 cycles; done pulses once.
REQ-033 SHALL test reset mid-DRAIN: pull rst low during the 2nd drain cycle -> all outputs 0 immediately, no done pulse, in_ready = 1 after release.
REQ-034 SHALL test back-to-back tiles: start a second tile immediately after done -> its first act_west row3 value is 0 (no residue from the previous tile).
REQ-035 SHALL test N=1: a 2-beat tile -> act_west equals the input beats with one cycle of latency, and done follows the last compute with no drain.
